// File: rtl/branch_redirect_ctrl_if.sv
// Front-end redirect bus between the EX/hazard side (master) and the redirect sequencer (slave).
// The master drives branch resolution and fetch status; the slave returns PC/pipeline controls.
interface branch_redirect_ctrl_if #(
  parameter int PC_W = 9
);
  logic            ex_valid;
  logic            ex_pcsel;
  logic [31:0]     ex_brpc;
  logic            stall_req;
  logic            fetch_ready;
  logic            pc_redirect;
  logic [PC_W-1:0] redirect_pc;
  logic            pc_write_en;
  logic            ifid_write_en;
  logic            flush_ifid;
  logic            flush_idex;

  modport master (
    output ex_valid, ex_pcsel, ex_brpc, stall_req, fetch_ready,
    input  pc_redirect, redirect_pc, pc_write_en, ifid_write_en, flush_ifid, flush_idex
  );

  modport slave (
    input  ex_valid, ex_pcsel, ex_brpc, stall_req, fetch_ready,
    output pc_redirect, redirect_pc, pc_write_en, ifid_write_en, flush_ifid, flush_idex
  );
endinterface

// File: rtl/branch_redirect_ctrl.sv
// Sequences front-end redirection for taken branches resolved in EX, holding the redirect
// while fetch is busy, merging load-use stalls and keeping saturating perf counters.
module branch_redirect_ctrl #(
  parameter int PC_W  = 9,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  branch_redirect_ctrl_if.slave  bus,
  input  logic                   cnt_clr,
  output logic                   target_err,
  output logic [CNT_W-1:0]       taken_cnt,
  output logic [CNT_W-1:0]       hold_cnt
);

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  logic [0:0]      state, state_nxt;
  logic [PC_W-1:0] pend_tgt;
  logic [PC_W-1:0] tgt;
  logic            in_hold;
  logic            taken;
  logic            bad_tgt;
  logic            latch_tgt;
  logic            redirect_done;

  // During reset the outputs behave as RUN with no valid instruction in EX.
  assign in_hold = (state == ST_HOLD) && !reset;
  assign taken   = !in_hold && !reset && bus.ex_valid && bus.ex_pcsel;
  assign tgt     = {bus.ex_brpc[PC_W-1:2], 2'b00};
  assign bad_tgt = (|bus.ex_brpc[1:0]) || (|bus.ex_brpc[31:PC_W]);

  always_comb begin
    // NOTE: every output gets a default first so no path through this block infers a latch.
    state_nxt         = state;
    latch_tgt         = 1'b0;
    redirect_done     = 1'b0;
    bus.pc_redirect   = 1'b0;
    bus.redirect_pc   = pend_tgt;
    bus.pc_write_en   = 1'b1;
    bus.ifid_write_en = 1'b1;
    bus.flush_ifid    = 1'b0;
    bus.flush_idex    = 1'b0;

    if (in_hold) begin
      // Wrong-path bubbles keep flowing until fetch takes the pending target.
      bus.flush_ifid  = 1'b1;
      bus.flush_idex  = 1'b1;
      bus.pc_redirect = bus.fetch_ready;
      bus.pc_write_en = bus.fetch_ready;
      redirect_done   = bus.fetch_ready;
      if (bus.fetch_ready) state_nxt = ST_RUN;
    end else if (taken) begin
      bus.flush_ifid = 1'b1;
      bus.flush_idex = 1'b1;
      if (bus.fetch_ready) begin
        bus.pc_redirect = 1'b1;
        bus.redirect_pc = tgt;
        redirect_done   = 1'b1;
      end else begin
        bus.pc_write_en = 1'b0;
        latch_tgt       = 1'b1;
        state_nxt       = ST_HOLD;
      end
    end else begin
      bus.pc_write_en   = !bus.stall_req;
      bus.ifid_write_en = !bus.stall_req;
      bus.flush_idex    = bus.stall_req;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state      <= ST_RUN;
      pend_tgt   <= '0;
      target_err <= 1'b0;
      taken_cnt  <= '0;
      hold_cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (latch_tgt) pend_tgt <= tgt;
      if (taken && bad_tgt) target_err <= 1'b1;

      // Clear beats a same-cycle increment; increments stop at all-ones.
      if (cnt_clr) begin
        taken_cnt <= '0;
        hold_cnt  <= '0;
      end else begin
        if (redirect_done && !(&taken_cnt)) taken_cnt <= taken_cnt + 1'b1;
        if (in_hold && !(&hold_cnt))        hold_cnt  <= hold_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Self-checking bench for branch_redirect_ctrl: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model of the redirect rules.
module tb_branch_redirect_ctrl;

  localparam int PC_W  = 9;
  localparam int CNT_W = 16;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk;
  logic             reset;
  logic             cnt_clr;
  logic             target_err;
  logic [CNT_W-1:0] taken_cnt;
  logic [CNT_W-1:0] hold_cnt;

  branch_redirect_ctrl_if #(.PC_W(PC_W)) bus ();

  branch_redirect_ctrl #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus.slave),
    .cnt_clr    (cnt_clr),
    .target_err (target_err),
    .taken_cnt  (taken_cnt),
    .hold_cnt   (hold_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit m_hold;
  int m_pend;
  int m_taken;
  int m_holdc;
  bit m_err;

  // Expected combinational outputs for the current cycle
  bit e_redir, e_pcwe, e_ifid, e_fl_ifid, e_fl_idex, e_show_pc, e_holding, e_taken;
  int e_pc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input bit v, input bit sel, input logic [31:0] brpc,
                        input bit stall, input bit fr, input bit clr);
    bus.ex_valid    = v;
    bus.ex_pcsel    = sel;
    bus.ex_brpc     = brpc;
    bus.stall_req   = stall;
    bus.fetch_ready = fr;
    cnt_clr         = clr;
  endtask

  function automatic int sat_inc(input int x);
    return (x >= CMAX) ? CMAX : x + 1;
  endfunction

  task automatic model_comb();
    e_holding = m_hold && !reset;
    e_taken   = !e_holding && !reset && bus.ex_valid && bus.ex_pcsel;
    e_show_pc = 1'b0;
    e_pc      = 0;
    if (e_holding) begin
      e_redir = bus.fetch_ready; e_pcwe = bus.fetch_ready; e_ifid = 1'b1;
      e_fl_ifid = 1'b1; e_fl_idex = 1'b1;
      e_show_pc = 1'b1; e_pc = m_pend;
    end else if (e_taken) begin
      e_redir = bus.fetch_ready; e_pcwe = bus.fetch_ready; e_ifid = 1'b1;
      e_fl_ifid = 1'b1; e_fl_idex = 1'b1;
      e_show_pc = bus.fetch_ready; e_pc = int'(bus.ex_brpc) & 'h1FC;
    end else begin
      e_redir = 1'b0; e_pcwe = !bus.stall_req; e_ifid = !bus.stall_req;
      e_fl_ifid = 1'b0; e_fl_idex = bus.stall_req;
    end
  endtask

  task automatic model_update();
    if (reset) begin
      m_hold = 0; m_pend = 0; m_taken = 0; m_holdc = 0; m_err = 0;
    end else begin
      if (e_holding) begin
        m_holdc = sat_inc(m_holdc);
        if (bus.fetch_ready) begin
          m_taken = sat_inc(m_taken);
          m_hold  = 0;
        end
      end else if (e_taken) begin
        if ((bus.ex_brpc % 4) != 0 || bus.ex_brpc >= (32'd1 << PC_W)) m_err = 1;
        if (bus.fetch_ready) m_taken = sat_inc(m_taken);
        else begin
          m_hold = 1;
          m_pend = int'(bus.ex_brpc) & 'h1FC;
        end
      end
      if (cnt_clr) begin
        m_taken = 0; m_holdc = 0;
      end
    end
  endtask

  // Called one time unit after a rising edge with inputs already applied.
  task automatic tick(input bit do_check);
    #4;
    model_comb();
    if (do_check) begin
      check("pc_redirect",   bus.pc_redirect,   e_redir);
      check("pc_write_en",   bus.pc_write_en,   e_pcwe);
      check("ifid_write_en", bus.ifid_write_en, e_ifid);
      check("flush_ifid",    bus.flush_ifid,    e_fl_ifid);
      check("flush_idex",    bus.flush_idex,    e_fl_idex);
      if (e_show_pc) check("redirect_pc", bus.redirect_pc, e_pc);
    end
    @(posedge clk);
    model_update();
    #1;
    if (do_check) begin
      check("target_err", target_err, m_err);
      check("taken_cnt",  taken_cnt,  m_taken);
      check("hold_cnt",   hold_cnt,   m_holdc);
    end
  endtask

  initial begin
    reset = 1'b1;
    set_in(0, 0, 0, 0, 1, 0);
    @(posedge clk);
    #1;

    // Reset cycle then idle RUN
    tick(1);
    reset = 1'b0;
    tick(1);
    check("idle_pc_write_en", bus.pc_write_en, 1);
    check("idle_taken_cnt", taken_cnt, 0);

    // Zero-latency redirect to 0x40
    set_in(1, 1, 32'h40, 0, 1, 0);
    tick(1);
    check("fast_taken_cnt", taken_cnt, 1);

    // Redirect to 0x80 held for 3 cycles by fetch_ready=0
    set_in(1, 1, 32'h80, 0, 0, 0);
    tick(1);
    set_in(1, 1, 32'h44, 1, 0, 0);
    tick(1);
    set_in(0, 0, 32'h0, 1, 0, 0);
    tick(1);
    set_in(1, 1, 32'h1C, 0, 1, 0);
    #4;
    check("hold_release_redirect", bus.pc_redirect, 1);
    check("hold_release_pc", bus.redirect_pc, 32'h080);
    #1;
    @(posedge clk);
    model_comb(); // state before the edge was HOLD with fetch_ready=1
    e_holding = 1'b1; e_taken = 1'b0;
    model_update();
    #1;
    check("hold_cnt_after", hold_cnt, 3);
    check("taken_cnt_after", taken_cnt, 2);

    // Load-use stall without and with a taken branch
    set_in(0, 0, 0, 1, 1, 0);
    tick(1);
    set_in(1, 1, 32'h10, 1, 1, 0);
    tick(1);

    // Bad targets: misaligned, then out of range
    set_in(1, 1, 32'h102, 0, 1, 0);
    tick(1);
    check("err_misaligned", target_err, 1);
    set_in(0, 0, 0, 0, 1, 0);
    tick(1);
    check("err_sticky", target_err, 1);
    reset = 1'b1; tick(1); reset = 1'b0;
    set_in(1, 1, 32'h200, 0, 1, 0);
    tick(1);
    check("err_range", target_err, 1);

    // Reset asserted while in HOLD
    set_in(1, 1, 32'h60, 0, 0, 0);
    tick(1);
    reset = 1'b1;
    set_in(0, 0, 0, 0, 1, 0);
    tick(1);
    reset = 1'b0;
    tick(1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 7) == 0) ? $urandom : (32'($urandom_range(0, 127)) << 2);
      reset = ($urandom_range(0, 39) == 0);
      set_in($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, a,
             $urandom_range(0, 3) == 0, $urandom_range(0, 2) != 0,
             $urandom_range(0, 29) == 0);
      tick(1);
    end
    reset = 1'b0;

    // Saturate taken_cnt
    set_in(0, 0, 0, 0, 1, 1);
    tick(1);
    set_in(1, 1, 32'h20, 0, 1, 0);
    for (int i = 0; i < CMAX + 3; i++) tick(0);
    check("sat_taken_cnt", taken_cnt, 32'hFFFF);
    tick(1);
    check("sat_stays", taken_cnt, 32'hFFFF);

    // Clear wins over a same-cycle redirect
    set_in(1, 1, 32'h24, 0, 1, 1);
    tick(1);
    check("clr_wins", taken_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
